vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart of the VGA scan-out path.
- Samples an incoming VGA stream (HSYNC/VSYNC, 1-bit R/G/B) on the system clock and decimates it to a 128x96 frame.
- Writes the captured frame into the shared 16K-entry video RAM through that RAM's write port, at address {row[6:0], col[6:0]}.
- One frame is captured per start request.

Parameters:
- H_SYNC_CYC, 192, clk cycles of HSYNC low pulse
- H_BP_CYC, 96, clk cycles of horizontal back porch
- H_PIX_CYC, 10, clk cycles per captured pixel (1280 active cycles / 128)
- V_SYNC_LINES, 2, lines of VSYNC low
- V_BP_LINES, 33, lines of vertical back porch
- V_LINE_REP, 5, input lines per captured row (480 / 96)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- cap_start  in  1  single-cycle pulse that arms a capture
- vga_hsync  in  1  incoming HSYNC, active low
- vga_vsync  in  1  incoming VSYNC, active low
- vga_red, vga_green, vga_blue  in  1 each  incoming colour bits
- wr_en  out  1  vram write strobe
- wr_addr  out  14  {row, col}
- wr_red, wr_green, wr_blue  out  1 each  write data
- busy  out  1  high from arm until frame_done
- frame_done  out  1  one-cycle pulse when the last pixel has been written

Behaviour:
- Reset (async, active-low): every output is 0, state is IDLE, all counters are 0.
- Input conditioning: all five VGA inputs pass through a two-flop synchroniser. The outputs are s_hsync, s_vsync and s_rgb. Every timing point below is defined on these s_* signals.
- Edge detection: hfall is asserted when s_hsync goes 1->0. vfall is asserted when s_vsync goes 1->0.
- Horizontal counter hcnt (11 bit):
  - Cleared to 0 in the cycle hfall is seen; increments every cycle after that.
  - Saturates at 2047.
  - H_START = H_SYNC_CYC + H_BP_CYC.
- Line counter vcnt (10 bit):
  - vfall clears vcnt to 0. The first hfall at or after vfall is line 0.
  - Each later hfall increments vcnt.
  - V_START = V_SYNC_LINES + V_BP_LINES.
- Active lines: line L is active when V_START <= L < V_START + 96*V_LINE_REP.
  - A sub-line counter (0..V_LINE_REP-1) and a row counter (0..95) advance on hfall.
  - Only lines with sub-line == 0 are captured.
- Sample point: pixel col (0..127) is sampled when hcnt == H_START + col*H_PIX_CYC + H_PIX_CYC/2. Implement this with a pixel-cell counter, not a multiplier.
- Write: in the cycle after the sample point, wr_en = 1 for exactly one cycle, with wr_addr = {row, col} and wr_rgb equal to the sampled s_rgb.
- wr_addr and wr_rgb hold their last values while wr_en = 0.
- FSM states:
  - IDLE: busy = 0. cap_start moves to ARMED.
  - ARMED: busy = 1. vfall moves to CAPTURE.
  - CAPTURE: writes are issued as described above. After the write of {95,127}, go to DONE.
  - DONE: frame_done = 1 for one cycle, then return to IDLE.
- Writes are issued only in CAPTURE. A stream running mid-frame when the block is armed is ignored until the next vfall.
- cap_start while busy = 1 is ignored.
- vfall during CAPTURE: abort the current capture and restart it from row 0, staying in CAPTURE. Writes already made are not undone.
- hfall before hcnt passes the last sample point (short line): the remaining pixels of that line are not written, and the row still advances.
- Reset asserted mid-capture: all state clears immediately. No partial write strobe may occur.

Optional Feature:
- Macro: VGA_CAPTURE_LINE_CHECK_EN.
- Defined:
  - Adds output sync_err (1 bit).
  - While in CAPTURE, each hfall compares hcnt+1 (the measured line period) against the expected total H_SYNC_CYC + H_BP_CYC + 128*H_PIX_CYC + 32.
  - A mismatch greater than +/-2 cycles sets sync_err.
  - sync_err is sticky and is cleared by reset or cap_start. Capture is not altered.
- Not defined: the sync_err port does not exist and there is no comparison logic.

Decomposition:
- Shared package vga_pkg holds:
  - the 128x96 geometry constants (H_PIXELS=128, V_ROWS=96, ADDR_W=14);
  - the default 640x480@60 / 50 MHz timing parameters;
  - the FSM state typedef.
- The synchroniser plus edge detector is a natural sub-module, vga_sync_edge (per-bit 2FF plus falling-edge pulse). Instantiate it for HSYNC and VSYNC; RGB uses the bare 2FF.

Test Plan:
- Reset low mid-CAPTURE -> wr_en, busy and frame_done are 0 within the same cycle; after release, state is IDLE.
- cap_start, then a full standard 640x480 frame with R = col[0] -> exactly 12288 wr_en pulses. The first is addr 0x0000; the last is addr {95,127} = 0x2FFF. red alternates 0/1 per col; frame_done pulses once, 1 cycle after the last write.
- Stream already mid-frame at cap_start -> no wr_en until the next vfall; then row 0 is written first.
- Second cap_start during CAPTURE -> ignored; write count is still 12288, with a single frame_done.
- vfall injected during row 40 -> the next write is addr {0,0}; capture completes with the final write at {95,127}.
- With VGA_CAPTURE_LINE_CHECK_EN: one line shortened to 1590 cycles -> sync_err = 1 after that hfall. It stays 1 until the next cap_start; a nominal 1600-cycle line leaves it at 0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared geometry, default timing and FSM state type for the VGA capture path
package vga_pkg;

    // Captured frame geometry and video RAM address width
    localparam int H_PIXELS = 128;
    localparam int V_ROWS   = 96;
    localparam int ADDR_W   = 14;

    // Default 640x480@60 timing expressed in 50 MHz system clock cycles
    localparam int DEF_H_SYNC_CYC   = 192;
    localparam int DEF_H_BP_CYC     = 96;
    localparam int DEF_H_PIX_CYC    = 10;
    localparam int DEF_V_SYNC_LINES = 2;
    localparam int DEF_V_BP_LINES   = 33;
    localparam int DEF_V_LINE_REP   = 5;

    // Line-period check: slack added to sync+porch+active, and allowed deviation
    localparam int LINE_MARGIN = 32;
    localparam int LINE_TOL    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - two-flop synchroniser with falling-edge pulse for one sync line
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   din    asynchronous input
//   s_out  synchronised level
//   fall   one-cycle pulse when s_out goes 1->0
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s_out,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // prev resets low so the idle-high sync rising out of reset never looks like an edge
    assign s_out = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - captures one decimated 128x96 VGA frame into video RAM per start request
//
// Optional feature macro: VGA_CAPTURE_LINE_CHECK_EN (adds sticky sync_err line-period checker)
//
// Ports:
//   clk, reset                 system clock, asynchronous active-low reset
//   cap_start                  one-cycle pulse arming a capture (ignored while busy)
//   vga_hsync, vga_vsync       incoming active-low syncs
//   vga_red/green/blue         incoming 1-bit colour
//   wr_en, wr_addr             video RAM write strobe and {row, col} address
//   wr_red/green/blue          video RAM write data
//   busy                       high from arm until frame_done
//   frame_done                 one-cycle pulse the cycle after the final write
//   sync_err                   (feature only) sticky line-period mismatch flag
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_SYNC_CYC   = DEF_H_SYNC_CYC,
    parameter int H_BP_CYC     = DEF_H_BP_CYC,
    parameter int H_PIX_CYC    = DEF_H_PIX_CYC,
    parameter int V_SYNC_LINES = DEF_V_SYNC_LINES,
    parameter int V_BP_LINES   = DEF_V_BP_LINES,
    parameter int V_LINE_REP   = DEF_V_LINE_REP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_start,
    input  logic              vga_hsync,
    input  logic              vga_vsync,
    input  logic              vga_red,
    input  logic              vga_green,
    input  logic              vga_blue,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_red,
    output logic              wr_green,
    output logic              wr_blue,
    output logic              busy,
    output logic              frame_done
`ifdef VGA_CAPTURE_LINE_CHECK_EN
    ,
    output logic              sync_err
`endif
);

    localparam int H_START = H_SYNC_CYC + H_BP_CYC;
    localparam logic [10:0] FIRST_SAMPLE = 11'(H_START + H_PIX_CYC / 2);
    localparam logic [4:0]  PH_LAST      = 5'(H_PIX_CYC - 1);
    localparam logic [9:0]  V_START_L    = 10'(V_SYNC_LINES + V_BP_LINES);
    localparam logic [9:0]  V_END_L      = 10'(V_SYNC_LINES + V_BP_LINES + V_ROWS * V_LINE_REP);
    localparam logic [3:0]  SUB_LAST     = 4'(V_LINE_REP - 1);
    localparam logic [6:0]  ROW_LAST     = 7'(V_ROWS - 1);
    localparam logic [6:0]  COL_LAST     = 7'(H_PIXELS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ROW_LAST, COL_LAST};

    // Input conditioning
    logic s_hsync, s_vsync, hfall, vfall;
    logic [2:0] rgb_meta_q, rgb_meta_d, s_rgb_q, s_rgb_d;

    vga_sync_edge u_hsync (.clk(clk), .reset(reset), .din(vga_hsync), .s_out(s_hsync), .fall(hfall));
    vga_sync_edge u_vsync (.clk(clk), .reset(reset), .din(vga_vsync), .s_out(s_vsync), .fall(vfall));

    // Counters and state
    cap_state_t state_q, state_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d, new_line;
    logic        vpend_q, vpend_d;
    logic        act_q, act_d;
    logic [6:0]  row_q, row_d;
    logic [3:0]  sub_q, sub_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  ph_q, ph_d;
    logic        pix_on_q, pix_on_d;
    logic        hit, sample;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        wr_rgb_q, wr_rgb_d;

    always_comb begin
        rgb_meta_d = {vga_red, vga_green, vga_blue};
        s_rgb_d    = rgb_meta_q;
    end

    always_comb begin
        hcnt_d = hcnt_q;
        if (hfall) begin
            hcnt_d = 11'd0;
        end else if (hcnt_q != 11'h7FF) begin
            hcnt_d = hcnt_q + 11'd1;
        end
    end

    // vpend remembers a vfall not yet followed by an hfall, so that hfall starts line 0.
    always_comb begin
        vcnt_d   = vcnt_q;
        vpend_d  = vpend_q;
        act_d    = act_q;
        row_d    = row_q;
        sub_d    = sub_q;
        new_line = (vfall || vpend_q) ? 10'd0 :
                   ((vcnt_q == 10'h3FF) ? vcnt_q : vcnt_q + 10'd1);
        if (hfall) begin
            vcnt_d  = new_line;
            vpend_d = 1'b0;
            act_d   = (new_line >= V_START_L) && (new_line < V_END_L);
            if (new_line == V_START_L) begin
                row_d = 7'd0;
                sub_d = 4'd0;
            end else if (act_d) begin
                if (sub_q == SUB_LAST) begin
                    sub_d = 4'd0;
                    row_d = row_q + 7'd1;
                end else begin
                    sub_d = sub_q + 4'd1;
                end
            end
        end else if (vfall) begin
            // Abandon the rest of the current line; a new frame is starting
            vcnt_d  = 10'd0;
            vpend_d = 1'b1;
            act_d   = 1'b0;
        end
    end

    // Pixel-cell walker: first sample at FIRST_SAMPLE, then every H_PIX_CYC cycles,
    // stopping after the last column so a long line cannot wrap back to column 0.
    always_comb begin
        col_d    = col_q;
        ph_d     = ph_q;
        pix_on_d = pix_on_q;
        hit      = 1'b0;
        if (hfall) begin
            col_d    = 7'd0;
            ph_d     = 5'd0;
            pix_on_d = 1'b0;
        end else if ((pix_on_q && (ph_q == PH_LAST)) ||
                     (!pix_on_q && (hcnt_q == FIRST_SAMPLE) && (col_q == 7'd0))) begin
            hit  = 1'b1;
            ph_d = 5'd0;
            if (col_q == COL_LAST) begin
                pix_on_d = 1'b0;
            end else begin
                pix_on_d = 1'b1;
                col_d    = col_q + 7'd1;
            end
        end else if (pix_on_q) begin
            ph_d = ph_q + 5'd1;
        end
    end

    // Pixels are only taken from the visible region, where both syncs are deasserted
    assign sample = hit && act_q && (sub_q == 4'd0) && (state_q == ST_CAPTURE) &&
                    !vfall && s_hsync && s_vsync;

    always_comb begin
        wr_en_d   = sample;
        wr_addr_d = sample ? {row_q, col_q} : wr_addr_q;
        wr_rgb_d  = sample ? s_rgb_q : wr_rgb_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cap_start) state_d = ST_ARMED;
            ST_ARMED:   if (vfall) state_d = ST_CAPTURE;
            ST_CAPTURE: if (wr_en_q && (wr_addr_q == LAST_ADDR)) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_meta_q <= 3'd0;
            s_rgb_q    <= 3'd0;
            state_q    <= ST_IDLE;
            hcnt_q     <= 11'd0;
            vcnt_q     <= 10'd0;
            vpend_q    <= 1'b0;
            act_q      <= 1'b0;
            row_q      <= 7'd0;
            sub_q      <= 4'd0;
            col_q      <= 7'd0;
            ph_q       <= 5'd0;
            pix_on_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_rgb_q   <= 3'd0;
        end else begin
            rgb_meta_q <= rgb_meta_d;
            s_rgb_q    <= s_rgb_d;
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            vpend_q    <= vpend_d;
            act_q      <= act_d;
            row_q      <= row_d;
            sub_q      <= sub_d;
            col_q      <= col_d;
            ph_q       <= ph_d;
            pix_on_q   <= pix_on_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_rgb_q   <= wr_rgb_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_red     = wr_rgb_q[2];
    assign wr_green   = wr_rgb_q[1];
    assign wr_blue    = wr_rgb_q[0];
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

`ifdef VGA_CAPTURE_LINE_CHECK_EN
    localparam int LINE_TOTAL = H_START + H_PIXELS * H_PIX_CYC + LINE_MARGIN;
    localparam logic [11:0] PER_MIN = 12'(LINE_TOTAL - LINE_TOL);
    localparam logic [11:0] PER_MAX = 12'(LINE_TOTAL + LINE_TOL);

    logic        sync_err_q, sync_err_d;
    logic [11:0] period;

    // hcnt holds period-1 in the cycle the closing hfall is seen
    always_comb begin
        period     = {1'b0, hcnt_q} + 12'd1;
        sync_err_d = sync_err_q;
        if (cap_start) begin
            sync_err_d = 1'b0;
        end else if ((state_q == ST_CAPTURE) && hfall && ((period < PER_MIN) || (period > PER_MAX))) begin
            sync_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err = sync_err_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - scoreboard bench for vga_capture with a reduced-timing VGA source
module tb_vga_capture;
    import vga_pkg::*;

    localparam int HS = 2, HBP = 2, HPIX = 2, VS = 1, VBP = 1, REP = 1;
    localparam int V_START  = VS + VBP;
    localparam int LINE_LEN = HS + HBP + H_PIXELS * HPIX + LINE_MARGIN;
    // Source drives pixel c over cycles [FIRST_T + c*HPIX, FIRST_T + (c+1)*HPIX) after the hsync fall
    localparam int FIRST_T  = HS + HBP + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cap_start = 1'b0;
    logic vga_hsync = 1'b1, vga_vsync = 1'b1;
    logic vga_red = 1'b0, vga_green = 1'b0, vga_blue = 1'b0;
    logic wr_en, wr_red, wr_green, wr_blue, busy, frame_done;
    logic [ADDR_W-1:0] wr_addr;
`ifdef VGA_CAPTURE_LINE_CHECK_EN
    logic sync_err;
`endif

    always #5 clk = ~clk;

    vga_capture #(
        .H_SYNC_CYC(HS), .H_BP_CYC(HBP), .H_PIX_CYC(HPIX),
        .V_SYNC_LINES(VS), .V_BP_LINES(VBP), .V_LINE_REP(REP)
    ) dut (
        .clk(clk), .reset(reset), .cap_start(cap_start),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
        .busy(busy), .frame_done(frame_done)
`ifdef VGA_CAPTURE_LINE_CHECK_EN
        , .sync_err(sync_err)
`endif
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        rgb;
    } exp_t;

    exp_t exp_q[$];
    int total = 0, bad = 0;
    int wr_cnt = 0, done_cnt = 0;
    int cap_pulse_row = -1, short_row = -1;
    int base_wr, base_done;

    function automatic logic [2:0] pix_rgb(input int row, input int c);
        logic [6:0] rr, cc;
        rr = row[6:0];
        cc = c[6:0];
        return {cc[0], cc[1] ^ rr[0], cc[2] ^ rr[2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive_line(input int row, input bit cap, input bit vlow);
        int len;
        exp_t e;
        logic [6:0] rr, cc;
        len = (row >= 0 && row == short_row) ? LINE_LEN - 10 : LINE_LEN;
        if (cap && row >= 0) begin
            for (int c = 0; c < H_PIXELS; c++) begin
                rr = row[6:0];
                cc = c[6:0];
                e.addr = {rr, cc};
                e.rgb  = pix_rgb(row, c);
                exp_q.push_back(e);
            end
        end
        for (int t = 0; t < len; t++) begin
            @(posedge clk);
            #1;
            vga_hsync = (t < HS) ? 1'b0 : 1'b1;
            if (t == 0) vga_vsync = vlow ? 1'b0 : 1'b1;
            cap_start = (cap_pulse_row >= 0 && row == cap_pulse_row && t == 100);
            if (row >= 0 && t >= FIRST_T && t < FIRST_T + H_PIXELS * HPIX)
                {vga_red, vga_green, vga_blue} = pix_rgb(row, (t - FIRST_T) / HPIX);
            else
                {vga_red, vga_green, vga_blue} = 3'b000;
        end
    endtask

    // Frame from the vsync fall through the line before row stop_row
    task automatic run_frame(input bit cap, input int stop_row);
        for (int l = 0; l < V_START + stop_row; l++)
            drive_line((l >= V_START) ? l - V_START : -1, cap, l < VS);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 cap_start = 1'b1;
        @(posedge clk);
        #1 cap_start = 1'b0;
    endtask

    task automatic monitor_loop();
        exp_t e;
        bit last_final;
        last_final = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done) begin
                done_cnt++;
                check("frame_done_after_final_write", {31'd0, last_final}, 32'd1);
            end
            last_final = 1'b0;
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", {18'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {18'd0, wr_addr}, {18'd0, e.addr});
                    check("write_rgb", {29'd0, wr_red, wr_green, wr_blue}, {29'd0, e.rgb});
                end
                last_final = (wr_addr == 14'h2FFF);
            end
        end
    endtask

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_wr_addr", {18'd0, wr_addr}, 32'd0);
        check("rst_wr_rgb", {29'd0, wr_red, wr_green, wr_blue}, 32'd0);
`ifdef VGA_CAPTURE_LINE_CHECK_EN
        check("rst_sync_err", {31'd0, sync_err}, 32'd0);
`endif
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);

        // Reset asserted while capturing
        base_wr = wr_cnt;
        pulse_start();
        run_frame(1'b1, 2);
        @(posedge clk);
        #1;
        check("busy_in_capture", {31'd0, busy}, 32'd1);
        check("writes_before_reset", 32'(wr_cnt - base_wr), 32'd256);
        reset = 1'b0;
        #1;
        check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        run_frame(1'b0, 3);
        #1;
        check("idle_after_reset", {31'd0, busy}, 32'd0);
        check("no_done_after_reset", 32'(done_cnt), 32'd0);

        // Arm mid-frame, second cap_start during capture, one full frame
        base_wr   = wr_cnt;
        base_done = done_cnt;
        cap_pulse_row = 91;
        for (int r = 90; r < 94; r++) drive_line(r, 1'b0, 1'b0);
        check("armed_busy", {31'd0, busy}, 32'd1);
        check("no_write_midframe", 32'(wr_cnt - base_wr), 32'd0);
        cap_pulse_row = 50;
        run_frame(1'b1, 96);
        cap_pulse_row = -1;
        repeat (4) @(posedge clk);
        #1;
        check("frame_write_count", 32'(wr_cnt - base_wr), 32'd12288);
        check("frame_done_count", 32'(done_cnt - base_done), 32'd1);
        check("frame_queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_after_frame", {31'd0, busy}, 32'd0);

        // vfall during row 40 restarts the capture from row 0
        base_wr   = wr_cnt;
        base_done = done_cnt;
        pulse_start();
        run_frame(1'b1, 40);
        run_frame(1'b1, 96);
        repeat (4) @(posedge clk);
        #1;
        check("abort_write_count", 32'(wr_cnt - base_wr), 32'd17408);
        check("abort_done_count", 32'(done_cnt - base_done), 32'd1);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef VGA_CAPTURE_LINE_CHECK_EN
        pulse_start();
        short_row = -1;
        run_frame(1'b1, 6);
        check("sync_err_nominal", {31'd0, sync_err}, 32'd0);
        short_row = 3;
        run_frame(1'b1, 6);
        short_row = -1;
        check("sync_err_sticky", {31'd0, sync_err}, 32'd1);
        pulse_start();
        #1;
        check("sync_err_cleared", {31'd0, sync_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
